// File: rtl/de2_input_pkg.sv
// Shared types and defaults for the DE2 key-capture front-end.
package de2_input_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int INSTR_W_DEF         = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VIEW  = 3'd1,
        S_ARM   = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    typedef struct packed {
        logic start;
        logic is_view;
        logic idle_op;
        logic idle_view;
    } out_t;

    // Output pattern presented while the FSM sits in a given state.
    function automatic out_t state_outputs(input state_t s);
        out_t o;
        o.start     = 1'b0;
        o.is_view   = 1'b0;
        o.idle_op   = 1'b1;
        o.idle_view = 1'b1;
        case (s)
            S_VIEW: begin
                o.is_view   = 1'b1;
                o.idle_view = 1'b0;
            end
            S_ARM, S_WAIT: begin
                o.idle_op = 1'b0;
            end
            S_START: begin
                o.idle_op = 1'b0;
                o.start   = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stable-sample debounce counter.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with it; any agreeing sample clears the count. Press and
// release are one-cycle pulses coincident with the level change.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit RST_VAL         = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw input into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Count disagreeing samples; accept the new level on the last one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_level   <= RST_VAL;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt     <= '0;
                r_level   <= r_sync;
                r_press   <= ~r_sync;
                r_release <= r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/de2_key_capture.sv
// DE2 input front-end: debounces KEY0 (view) and KEY3 (execute), latches the
// instruction from SW on an execute press and runs the start/ready handshake.
// Optional macro DE2_GO_GATE_EN: when defined, an execute press is accepted
// only while the debounced GO switch is high; otherwise GO is ignored.
module de2_key_capture
    import de2_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int INSTR_W         = INSTR_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               KEY0,
    input  logic               KEY3,
    input  logic               GO,
    input  logic [INSTR_W-1:0] SW,
    input  logic               ready,
    output logic               start,
    output logic [INSTR_W-1:0] instr,
    output logic               isView,
    output logic               idle_op,
    output logic               idle_view
);

    logic w_k0_level, w_k0_press, w_k0_release;
    logic w_k3_level, w_k3_press, w_k3_release;
    logic w_go_ok;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RST_VAL         (1'b1)
    ) u_key0 (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_raw     (KEY0),
        .o_level   (w_k0_level),
        .o_press   (w_k0_press),
        .o_release (w_k0_release)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RST_VAL         (1'b1)
    ) u_key3 (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_raw     (KEY3),
        .o_level   (w_k3_level),
        .o_press   (w_k3_press),
        .o_release (w_k3_release)
    );

`ifdef DE2_GO_GATE_EN
    logic w_go_level;
    logic w_go_unused_press;
    logic w_go_unused_release;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RST_VAL         (1'b0)
    ) u_go (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_raw     (GO),
        .o_level   (w_go_level),
        .o_press   (w_go_unused_press),
        .o_release (w_go_unused_release)
    );

    assign w_go_ok = w_go_level;
`else
    logic w_unused_go;
    assign w_unused_go = GO;
    assign w_go_ok     = 1'b1;
`endif

    logic [INSTR_W-1:0] r_sw_meta;
    logic [INSTR_W-1:0] r_sw_sync;
    logic [INSTR_W-1:0] r_instr;
    state_t             r_state;
    out_t               r_out;

    // Synchronize the instruction switches before they are latched.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Control FSM; outputs are registered together with the state they belong to.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_out   <= state_outputs(S_IDLE);
            r_instr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_k3_level && w_k0_press) begin
                        r_state <= S_VIEW;
                        r_out   <= state_outputs(S_VIEW);
                    end else if (w_k0_level && w_k3_press && w_go_ok) begin
                        r_state <= S_ARM;
                        r_out   <= state_outputs(S_ARM);
                        r_instr <= r_sw_sync;
                    end
                end
                S_VIEW: begin
                    if (w_k0_release || w_k3_press) begin
                        r_state <= S_IDLE;
                        r_out   <= state_outputs(S_IDLE);
                    end
                end
                S_ARM: begin
                    if (ready) begin
                        r_state <= S_START;
                        r_out   <= state_outputs(S_START);
                    end else if (w_k3_release) begin
                        r_state <= S_IDLE;
                        r_out   <= state_outputs(S_IDLE);
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_out   <= state_outputs(S_WAIT);
                end
                S_WAIT: begin
                    // Waiting for key release keeps one press to one start.
                    if (w_k3_level && ready) begin
                        r_state <= S_IDLE;
                        r_out   <= state_outputs(S_IDLE);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_out   <= state_outputs(S_IDLE);
                end
            endcase
        end
    end

    assign start     = r_out.start;
    assign isView    = r_out.is_view;
    assign idle_op   = r_out.idle_op;
    assign idle_view = r_out.idle_view;
    assign instr     = r_instr;

endmodule

// File: tb/tb_de2_key_capture.sv
// Directed bench for de2_key_capture with DEBOUNCE_CYCLES = 4.
// Timing used throughout: an input driven just after clock edge 0 is first
// sampled at edge 1, debounced at edge 6, the FSM moves at edge 7 and a
// START state (ready already high) is visible after edge 8.
module tb_de2_key_capture;

    localparam int DB = 4;

    logic        CLK;
    logic        RST;
    logic        KEY0;
    logic        KEY3;
    logic        GO;
    logic [15:0] SW;
    logic        ready;
    logic        start;
    logic [15:0] instr;
    logic        isView;
    logic        idle_op;
    logic        idle_view;

    int n_checks;
    int n_fail;
    int n_start;

    de2_key_capture #(
        .DEBOUNCE_CYCLES (DB),
        .INSTR_W         (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY0      (KEY0),
        .KEY3      (KEY3),
        .GO        (GO),
        .SW        (SW),
        .ready     (ready),
        .start     (start),
        .instr     (instr),
        .isView    (isView),
        .idle_op   (idle_op),
        .idle_view (idle_view)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count start pulses, sampled mid-cycle.
    always @(negedge CLK) begin
        if (start === 1'b1) n_start++;
    end

    typedef struct {
        logic        k0;
        logic        k3;
        logic        rdy;
        logic [15:0] sw;
        int          cyc;
        logic        vw;
        logic        iop;
        logic        iv;
        logic [15:0] ins;
        int          starts;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".isView"}, {31'd0, isView}, 32'd0);
        chk({nm, ".idle_op"}, {31'd0, idle_op}, 32'd1);
        chk({nm, ".idle_view"}, {31'd0, idle_view}, 32'd1);
        chk({nm, ".start"}, {31'd0, start}, 32'd0);
    endtask

    initial begin
        int base;
        n_checks = 0;
        n_fail   = 0;
        n_start  = 0;

        //                k0    k3    rdy   sw        cyc vw    iop   iv    ins       st
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0F0F, 7,  1'b1, 1'b1, 1'b0, 16'h0F0F, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0F0F, 7,  1'b0, 1'b1, 1'b1, 16'h0F0F, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0F0F, 7,  1'b1, 1'b1, 1'b0, 16'h0F0F, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h0F0F, 7,  1'b0, 1'b1, 1'b1, 16'h0F0F, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0F0F, 10, 1'b0, 1'b1, 1'b1, 16'h0F0F, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0F0F, 10, 1'b0, 1'b1, 1'b1, 16'h0F0F, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0F0F, 10, 1'b0, 1'b1, 1'b1, 16'h0F0F, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0F0F, 10, 1'b0, 1'b1, 1'b1, 16'h0F0F, 0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h00FF, 10, 1'b0, 1'b0, 1'b1, 16'h00FF, 1};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 16'h00FF, 8,  1'b0, 1'b1, 1'b1, 16'h00FF, 0};

        // Reset held with keys toggling.
        RST   = 1'b0;
        KEY0  = 1'b1;
        KEY3  = 1'b1;
        GO    = 1'b0;
        SW    = 16'hFFFF;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            KEY0 = i[0];
            KEY3 = ~i[1];
            tick(1);
            chk("reset.outputs", {12'd0, start, instr, isView, idle_op, idle_view},
                {12'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1});
        end
        KEY0 = 1'b1;
        KEY3 = 1'b1;
        SW   = 16'h0000;
        tick(1);
        RST = 1'b1;
        tick(10);
        chk_idle("post_reset");
        chk("post_reset.instr", {16'd0, instr}, 32'h0000);

        // Bounce: KEY3 flips every 2 cycles, never stable for DB samples.
        base = n_start;
        for (int i = 0; i < 10; i++) begin
            KEY3 = i[0];
            tick(2);
            chk("bounce.idle_op", {31'd0, idle_op}, 32'd1);
        end
        KEY3 = 1'b1;
        tick(10);
        chk_idle("bounce.end");
        chk("bounce.starts", n_start - base, 32'd0);

        // Execute with ready already high.
        base  = n_start;
        SW    = 16'h1A2B;
        ready = 1'b1;
        KEY3  = 1'b0;
        tick(6);
        chk("exec.still_idle", {31'd0, idle_op}, 32'd1);
        tick(1);
        chk("exec.arm.idle_op", {31'd0, idle_op}, 32'd0);
        chk("exec.arm.start", {31'd0, start}, 32'd0);
        tick(1);
        chk("exec.start", {31'd0, start}, 32'd1);
        chk("exec.instr", {16'd0, instr}, 32'h1A2B);
        tick(1);
        chk("exec.start_drop", {31'd0, start}, 32'd0);
        chk("exec.wait.idle_op", {31'd0, idle_op}, 32'd0);
        SW = 16'h0000;
        tick(20);
        chk("exec.instr_hold", {16'd0, instr}, 32'h1A2B);
        chk("exec.one_pulse", n_start - base, 32'd1);
        chk("exec.still_wait", {31'd0, idle_op}, 32'd0);
        KEY3 = 1'b1;
        tick(6);
        chk("exec.wait_release", {31'd0, idle_op}, 32'd0);
        tick(1);
        chk_idle("exec.back_idle");
        chk("exec.total_pulses", n_start - base, 32'd1);

        // Handshake: ready low during press, raised later.
        base  = n_start;
        ready = 1'b0;
        SW    = 16'h5A5A;
        KEY3  = 1'b0;
        tick(7);
        chk("hs.arm", {31'd0, idle_op}, 32'd0);
        tick(10);
        chk("hs.held.start", {31'd0, start}, 32'd0);
        chk("hs.held.idle_op", {31'd0, idle_op}, 32'd0);
        ready = 1'b1;
        tick(1);
        chk("hs.start", {31'd0, start}, 32'd1);
        chk("hs.instr", {16'd0, instr}, 32'h5A5A);
        tick(1);
        chk("hs.start_drop", {31'd0, start}, 32'd0);
        KEY3 = 1'b1;
        tick(8);
        chk_idle("hs.idle");
        chk("hs.pulses", n_start - base, 32'd1);

        // Abort: KEY3 released while still waiting for ready.
        base  = n_start;
        ready = 1'b0;
        SW    = 16'h0F0F;
        KEY3  = 1'b0;
        tick(7);
        chk("abort.arm", {31'd0, idle_op}, 32'd0);
        KEY3 = 1'b1;
        tick(6);
        chk("abort.still_arm", {31'd0, idle_op}, 32'd0);
        tick(1);
        chk_idle("abort.idle");
        chk("abort.pulses", n_start - base, 32'd0);
        chk("abort.instr", {16'd0, instr}, 32'h0F0F);

        // View and key-combination table.
        for (int v = 0; v < 10; v++) begin
            base  = n_start;
            KEY0  = vecs[v].k0;
            KEY3  = vecs[v].k3;
            ready = vecs[v].rdy;
            SW    = vecs[v].sw;
            tick(vecs[v].cyc);
            chk($sformatf("vec%0d.isView", v), {31'd0, isView}, {31'd0, vecs[v].vw});
            chk($sformatf("vec%0d.idle_op", v), {31'd0, idle_op}, {31'd0, vecs[v].iop});
            chk($sformatf("vec%0d.idle_view", v), {31'd0, idle_view}, {31'd0, vecs[v].iv});
            chk($sformatf("vec%0d.instr", v), {16'd0, instr}, {16'd0, vecs[v].ins});
            chk($sformatf("vec%0d.starts", v), n_start - base, vecs[v].starts);
        end

        // Reset asserted during START.
        base  = n_start;
        ready = 1'b1;
        SW    = 16'h3C3C;
        KEY3  = 1'b0;
        tick(8);
        chk("rst_mid.start", {31'd0, start}, 32'd1);
        #1;
        RST = 1'b0;
        #1;
        chk("rst_mid.outputs", {12'd0, start, instr, isView, idle_op, idle_view},
            {12'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1});
        KEY3 = 1'b1;
        tick(3);
        RST = 1'b1;
        tick(15);
        chk_idle("rst_mid.after");
        chk("rst_mid.pulses", n_start - base, 32'd0);
        chk("rst_mid.instr", {16'd0, instr}, 32'h0000);

        // GO handling.
        base = n_start;
        GO   = 1'b0;
        SW   = 16'h7777;
        KEY3 = 1'b0;
        tick(12);
`ifdef DE2_GO_GATE_EN
        chk("gate.go0.idle_op", {31'd0, idle_op}, 32'd1);
        chk("gate.go0.pulses", n_start - base, 32'd0);
        KEY3 = 1'b1;
        tick(8);
        GO = 1'b1;
        tick(8);
        base = n_start;
        KEY3 = 1'b0;
        tick(12);
`endif
        chk("gate.go.wait", {31'd0, idle_op}, 32'd0);
        chk("gate.go.pulses", n_start - base, 32'd1);
        chk("gate.go.instr", {16'd0, instr}, 32'h7777);
        KEY3 = 1'b1;
        tick(8);
        chk_idle("gate.end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
